// File: rtl/xillybus_stream_hub.sv
// Joins NUM_IN Xillybus write streams into tuples for a compute core and returns its results on one read stream.
// Optional: define XILLY_HUB_COUNT_EN to add the saturating join_count output.
module xillybus_stream_hub #(
    parameter int NUM_IN    = 2,
    parameter int DATA_W    = 32,
    parameter int IN_DEPTH  = 16,
    parameter int OUT_DEPTH = 16
) (
    input  logic                     bus_clk,
    input  logic                     bus_rst,
    input  logic [NUM_IN-1:0]        user_w_wren,
    input  logic [NUM_IN*DATA_W-1:0] user_w_data,
    output logic [NUM_IN-1:0]        user_w_full,
    input  logic [NUM_IN-1:0]        user_w_open,
    output logic                     join_valid,
    output logic [NUM_IN*DATA_W-1:0] join_data,
    input  logic                     join_ready,
    input  logic                     res_valid,
    input  logic [DATA_W-1:0]        res_data,
    output logic                     res_ready,
    input  logic                     user_r_rden,
    output logic [DATA_W-1:0]        user_r_data,
    output logic                     user_r_empty,
    output logic                     user_r_eof,
    input  logic                     user_r_open,
    output logic                     ovf_err
`ifdef XILLY_HUB_COUNT_EN
    ,
    output logic [31:0]              join_count
`endif
);
    localparam int IPTR_W = $clog2(IN_DEPTH);
    localparam int ILVL_W = IPTR_W + 1;
    localparam int OPTR_W = $clog2(OUT_DEPTH);
    localparam int OLVL_W = OPTR_W + 1;
    localparam logic [ILVL_W-1:0] IN_MAX     = ILVL_W'(IN_DEPTH);
    localparam logic [OLVL_W-1:0] OUT_MAX    = OLVL_W'(OUT_DEPTH);
    localparam logic [OLVL_W:0]   CREDIT_LIM = (OLVL_W + 1)'(OUT_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state_reg, state_next;

    logic [NUM_IN-1:0] in_at_max, in_empty, in_push;
    logic              accept_mode, flush, join_fire;
    logic [OLVL_W-1:0] outstanding_reg, out_level_reg;
    logic [OPTR_W-1:0] out_wr_ptr_reg, out_rd_ptr_reg;
    logic [OLVL_W:0]   credit_used;
    logic              res_push, r_pop, ovf_reg;
    logic [DATA_W-1:0] out_mem [OUT_DEPTH];

    assign accept_mode = (state_reg == RUN) || (state_reg == DRAIN);
    // Input FIFOs are discarded exactly once, on the cycle that enters DONE.
    assign flush       = (state_next == DONE) && (state_reg != DONE);

    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (&user_w_open) state_next = RUN;
            RUN:     if (!(&user_w_open)) state_next = DRAIN;
            DRAIN:   if ((|(~user_w_open & in_empty)) && (outstanding_reg == '0)) state_next = DONE;
            DONE:    if (!user_r_open && !(|user_w_open)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        user_w_full = '1;
        if (state_reg == RUN)        user_w_full = in_at_max;
        else if (state_reg == DRAIN) user_w_full = in_at_max | ~user_w_open;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_in
            logic [DATA_W-1:0] mem [IN_DEPTH];
            logic [IPTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
            logic [ILVL_W-1:0] level_reg;

            assign in_at_max[gi] = (level_reg == IN_MAX);
            assign in_empty[gi]  = (level_reg == '0);
            assign in_push[gi]   = user_w_wren[gi] & ~user_w_full[gi];
            assign join_data[gi*DATA_W +: DATA_W] = mem[rd_ptr_reg];

            always_ff @(posedge bus_clk) begin
                if (in_push[gi]) mem[wr_ptr_reg] <= user_w_data[gi*DATA_W +: DATA_W];
            end

            always_ff @(posedge bus_clk or posedge bus_rst) begin
                if (bus_rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    level_reg  <= '0;
                end else if (flush) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    level_reg  <= '0;
                end else begin
                    if (in_push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (join_fire)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    case ({in_push[gi], join_fire})
                        2'b10:   level_reg <= level_reg + 1'b1;
                        2'b01:   level_reg <= level_reg - 1'b1;
                        default: level_reg <= level_reg;
                    endcase
                end
            end
        end
    endgenerate

    // Credit: never issue a tuple whose result could not find room in the result FIFO.
    assign credit_used = {1'b0, outstanding_reg} + {1'b0, out_level_reg};
    assign join_valid  = accept_mode && !(|in_empty) && (credit_used < CREDIT_LIM);
    assign join_fire   = join_valid && join_ready;

    assign res_ready    = (out_level_reg != OUT_MAX);
    assign res_push     = res_valid && res_ready;
    assign user_r_empty = (out_level_reg == '0);
    assign r_pop        = user_r_rden && !user_r_empty;
    assign user_r_eof   = (state_reg == DONE) && user_r_empty;
    assign ovf_err      = ovf_reg;

    always_ff @(posedge bus_clk) begin
        if (res_push) out_mem[out_wr_ptr_reg] <= res_data;
    end

    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            out_wr_ptr_reg  <= '0;
            out_rd_ptr_reg  <= '0;
            out_level_reg   <= '0;
            outstanding_reg <= '0;
            user_r_data     <= '0;
        end else begin
            if (res_push) out_wr_ptr_reg <= out_wr_ptr_reg + 1'b1;
            if (r_pop) begin
                out_rd_ptr_reg <= out_rd_ptr_reg + 1'b1;
                user_r_data    <= out_mem[out_rd_ptr_reg];
            end
            case ({res_push, r_pop})
                2'b10:   out_level_reg <= out_level_reg + 1'b1;
                2'b01:   out_level_reg <= out_level_reg - 1'b1;
                default: out_level_reg <= out_level_reg;
            endcase
            // An unsolicited result (nothing outstanding) must not wrap the counter.
            case ({join_fire, res_push})
                2'b10:   outstanding_reg <= outstanding_reg + 1'b1;
                2'b01:   if (outstanding_reg != '0) outstanding_reg <= outstanding_reg - 1'b1;
                default: outstanding_reg <= outstanding_reg;
            endcase
        end
    end

    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) ovf_reg <= 1'b0;
        else if ((accept_mode && (|(user_w_wren & in_at_max))) ||
                 (res_push && (outstanding_reg == '0)))
            ovf_reg <= 1'b1;
    end

`ifdef XILLY_HUB_COUNT_EN
    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) join_count <= '0;
        else if ((state_reg == IDLE) && (state_next == RUN)) join_count <= '0;
        else if (join_fire && (join_count != 32'hFFFF_FFFF)) join_count <= join_count + 1'b1;
    end
`endif
endmodule

// File: doc/xillybus_stream_hub.md
Name: xillybus_stream_hub

Overview:
- Parametrised stream front-end between the Xillybus core streams and a user compute core; generalises the fixed two-write-stream / one-read-stream arrangement to NUM_IN write channels.
- Buffers each write channel in its own FIFO and joins one word from every channel into a tuple for the core.
- Buffers core results for a single read stream and generates end-of-file from stream open/close state.

Parameters:
NUM_IN, 2, number of Xillybus write streams joined (1..8)
DATA_W, 32, word width of every stream and of results
IN_DEPTH, 16, per-channel input FIFO depth (power of 2, >=2)
OUT_DEPTH, 16, result FIFO depth (power of 2, >=2)

Ports:
bus_clk  in  1  single clock for all logic
bus_rst  in  1  asynchronous reset, active-high
user_w_wren  in  NUM_IN  per-channel write strobe
user_w_data  in  NUM_IN*DATA_W  per-channel write data, channel k at [k*DATA_W +: DATA_W]
user_w_full  out  NUM_IN  per-channel full
user_w_open  in  NUM_IN  per-channel stream open
join_valid  out  1  tuple available to core
join_data  out  NUM_IN*DATA_W  tuple, same packing as user_w_data
join_ready  in  1  core accepts tuple
res_valid  in  1  core result strobe
res_data  in  DATA_W  core result
res_ready  out  1  result FIFO not full
user_r_rden  in  1  read-stream pop
user_r_data  out  DATA_W  read-stream data
user_r_empty  out  1  result FIFO empty
user_r_eof  out  1  end of file
user_r_open  in  1  read stream open
ovf_err  out  1  sticky overflow flag

Behaviour:
- Reset state: IDLE, all FIFOs empty, outstanding=0. Outputs: user_w_full all 1, join_valid 0, res_ready 1, user_r_data 0, user_r_empty 1, user_r_eof 0, ovf_err 0.
- States and transitions:
  - IDLE -> RUN when all user_w_open=1.
  - RUN -> DRAIN when any user_w_open=0.
  - DRAIN -> DONE when some closed channel's FIFO is empty and outstanding=0.
  - DONE -> IDLE when user_r_open=0 and all user_w_open=0.
  - All input FIFOs are flushed on entry to DONE; leftover words are discarded.
- Input path:
  - In RUN and DRAIN, user_w_full[k] = (level_k==IN_DEPTH). A closed channel in DRAIN reads full=1.
  - In IDLE and DONE, user_w_full = all 1.
  - A write is accepted when wren[k] & !full[k]; the word is visible to the join logic on the next cycle.
  - wren[k] while level_k==IN_DEPTH in RUN/DRAIN: word dropped, ovf_err set. Writes in IDLE/DONE are ignored without an error.
- Join:
  - join_valid = (RUN|DRAIN) & every FIFO non-empty & (outstanding + out_level < OUT_DEPTH).
  - join_data is FIFO heads, first-word-fall-through.
  - join_valid & join_ready pops all FIFOs in the same cycle and increments outstanding.
  - Once asserted, join_valid holds until accepted.
  - A simultaneous write and pop on one channel leaves the level unchanged.
- Results:
  - res_ready = !out_full. The credit rule guarantees res_ready stays 1 for legal cores.
  - res_valid & res_ready pushes the result and decrements outstanding.
  - res_valid with outstanding=0 pushes the result and sets ovf_err.
  - A simultaneous join and result leaves outstanding unchanged.
- Read stream:
  - user_r_rden & !user_r_empty at cycle N pops; user_r_data is registered and valid at N+1, held otherwise.
  - rden while empty is ignored.
  - A push at N deasserts user_r_empty at N+1.
  - user_r_eof = DONE & user_r_empty.
- ovf_err clears only on reset.
- Reset mid-operation: immediate return to reset state; contents are lost.

Optional Feature:
XILLY_HUB_COUNT_EN:
- Defined: adds output join_count [31:0], cleared on reset and on IDLE->RUN. Increments on each join handshake and saturates at 0xFFFFFFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- NUM_IN=2: open both, write x=1,2,3 and y=10,20,30, join_ready=1 -> join_data {10,1},{20,2},{30,3} in order, each exactly once.
- Write 17 words to channel 0 (IN_DEPTH=16) with channel 1 idle -> user_w_full[0]=1 after the 16th word, 17th word dropped, ovf_err=1, FIFO holds 1..16.
- Core holds join_ready=0 after tuples accepted while results are not read -> join_valid gated once outstanding+out_level=16; res_ready never 0.
- Result 0xA5 pushed at cycle N, rden at N+1 -> user_r_data=0xA5 at N+2, user_r_empty=1 at N+2.
- Close channel 1 with channel 0 holding 3 extra words, all results drained -> DONE, user_r_eof=1 with empty, channel-0 leftovers flushed; close all streams -> IDLE.
- Assert bus_rst mid-join with 5 words queued -> all outputs at reset values the same cycle; reopen -> no stale data.
